// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD stopwatch controller.
package bcd_pkg;

  localparam int BCD_DIGITS = 4;
  localparam int DIGIT_W    = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_digit.sv
// One decimal digit of the stopwatch count. It wraps 9 -> 0 and raises carry
// in the same cycle so that the next digit up advances with it.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               inc,
  output logic [DIGIT_W-1:0] digit,
  output logic               carry
);

  assign carry = inc && (digit == DIGIT_W'(9));

  // Digit register: cleared by reset or clear, otherwise steps by one on inc.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      digit <= '0;
    end else if (inc) begin
      digit <= carry ? '0 : digit + DIGIT_W'(1);
    end
  end

endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// Stopwatch controller: a command FSM, a tick prescaler, a four-digit BCD
// counter chain, a lap capture register and a sticky overflow flag.
//
//   state  | meaning
//   -------+---------------------------------------------------------
//   IDLE   | count zeroed, prescaler stopped, lap commands ignored
//   RUN    | prescaler advancing, count increments on every tick
//   PAUSED | count and partial prescaler period frozen until start
//
// Commands are levels sampled every cycle. Only the highest-priority asserted
// command (clear > stop > start > lap) takes effect in a given cycle.
module bcd_stopwatch_ctrl
  import bcd_pkg::*;
#(
  parameter int TICK_DIV = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  input  logic        lap,
  output logic [15:0] bcd_out,
  output logic [15:0] lap_out,
  output logic        lap_valid,
  output logic        running,
  output logic        overflow
);

  localparam logic [15:0] PRE_LAST = 16'(TICK_DIV - 1);

  state_t              state;
  state_t              state_nxt;
  logic [15:0]         prescaler;
  logic                tick;
  logic                inc;
  logic                lap_take;
  logic [BCD_DIGITS:0] chain;

  assign tick     = (state == RUN) && (prescaler == PRE_LAST);
  // A stop or clear arriving on the tick cycle swallows that increment.
  assign inc      = tick && !clear && !stop;
  assign lap_take = lap && !clear && !stop && !start && (state != IDLE);
  assign running  = (state == RUN);
  assign chain[0] = inc;

  // Next-state decode in command priority order.
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = IDLE;
    end else if (stop) begin
      if (state == RUN) state_nxt = PAUSED;
    end else if (start) begin
      state_nxt = RUN;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Prescaler advances only in RUN; PAUSED keeps the partial period.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      prescaler <= '0;
    end else if (state == RUN) begin
      prescaler <= tick ? '0 : prescaler + 16'd1;
    end
  end

  // Lap capture takes the count as it stood before this edge.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      lap_out   <= '0;
      lap_valid <= 1'b0;
    end else begin
      lap_valid <= lap_take;
      if (lap_take) lap_out <= bcd_out;
    end
  end

  // Sticky overflow, set when the top digit carries out (9999 -> 0000).
  always_ff @(posedge clk) begin
    if (reset || clear)           overflow <= 1'b0;
    else if (chain[BCD_DIGITS])   overflow <= 1'b1;
  end

  for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk   (clk),
      .reset (reset),
      .clr   (clear),
      .inc   (chain[i]),
      .digit (bcd_out[i*DIGIT_W +: DIGIT_W]),
      .carry (chain[i+1])
    );
  end

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Self-checking bench for bcd_stopwatch_ctrl with TICK_DIV = 2.
// Expectations are queued as stimulus is applied and compared one step later.
module tb_bcd_stopwatch_ctrl;
  import bcd_pkg::*;

  localparam int TD = 2;

  localparam int S_BCD = 0;
  localparam int S_LAP = 1;
  localparam int S_LV  = 2;
  localparam int S_RUN = 3;
  localparam int S_OVF = 4;
  localparam int S_ST  = 5;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stop  = 1'b0;
  logic        clear = 1'b0;
  logic        lap   = 1'b0;
  logic [15:0] bcd_out;
  logic [15:0] lap_out;
  logic        lap_valid;
  logic        running;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    int          sig;
    logic [15:0] exp;
  } exp_t;

  exp_t sb[$];

  bcd_stopwatch_ctrl #(.TICK_DIV(TD)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .clear     (clear),
    .lap       (lap),
    .bcd_out   (bcd_out),
    .lap_out   (lap_out),
    .lap_valid (lap_valid),
    .running   (running),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] obs(input int sig);
    case (sig)
      S_BCD:   return bcd_out;
      S_LAP:   return lap_out;
      S_LV:    return {15'd0, lap_valid};
      S_RUN:   return {15'd0, running};
      S_OVF:   return {15'd0, overflow};
      S_ST:    return 16'(dut.state);
      default: return 16'hdead;
    endcase
  endfunction

  // Independent decimal model of a one-step count advance.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    int n;
    n = int'(v[15:12]) * 1000 + int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
    n = (n + 1) % 10000;
    return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  task automatic want(input string tag, input int sig, input logic [15:0] exp);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, obs(e.sig), e.exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drain();
  endtask

  initial begin
    logic [15:0] prev;
    bit          found;

    // Reset held two cycles with start asserted.
    reset = 1'b1; start = 1'b1;
    step();
    want("rst_bcd", S_BCD, 16'h0000);
    want("rst_run", S_RUN, 16'd0);
    want("rst_ovf", S_OVF, 16'd0);
    want("rst_st",  S_ST,  16'(IDLE));
    want("rst_lap", S_LAP, 16'h0000);
    want("rst_lv",  S_LV,  16'd0);
    step();

    // Start in the first cycle after reset release.
    reset = 1'b0;
    want("start_run", S_RUN, 16'd1);
    want("start_bcd", S_BCD, 16'h0000);
    step();
    start = 1'b0;
    repeat (18) step();
    want("at_9", S_BCD, 16'h0009);
    step();
    want("nine_to_ten", S_BCD, 16'h0010);
    want("run20_run",   S_RUN, 16'd1);
    step();

    // Stop mid-period, wait, resume: one remaining prescaler cycle.
    stop = 1'b1;
    want("stop_run", S_RUN, 16'd0);
    want("stop_st",  S_ST,  16'(PAUSED));
    step();
    stop = 1'b0;
    repeat (49) step();
    want("pause_hold", S_BCD, 16'h0010);
    want("pause_run",  S_RUN, 16'd0);
    step();
    start = 1'b1;
    want("resume_run", S_RUN, 16'd1);
    want("resume_bcd", S_BCD, 16'h0010);
    step();
    start = 1'b0;
    want("resume_inc", S_BCD, 16'h0011);
    step();

    // Stop coincident with tick suppresses the increment.
    step();
    stop = 1'b1;
    want("stoptick_bcd", S_BCD, 16'h0011);
    want("stoptick_run", S_RUN, 16'd0);
    want("stoptick_st",  S_ST,  16'(PAUSED));
    step();
    stop = 1'b0;

    // Run up to 0x0042, checking every increment against the model.
    start = 1'b1;
    step();
    start = 1'b0;
    prev  = bcd_out;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      step();
      if (bcd_out !== prev) begin
        chk("seq", bcd_out, bcd_inc(prev));
        prev = bcd_out;
      end
      if (bcd_out == 16'h0042) found = 1'b1;
    end
    if (!found) chk("reach_42", bcd_out, 16'h0042);

    // Lap coincident with tick captures the pre-increment value.
    step();
    lap = 1'b1;
    want("lap_out",  S_LAP, 16'h0042);
    want("lap_lv",   S_LV,  16'd1);
    want("lap_bcd",  S_BCD, 16'h0043);
    step();
    lap = 1'b0;
    want("lap_lv_drop", S_LV,  16'd0);
    want("lap_hold",    S_LAP, 16'h0042);
    want("lap_bcd2",    S_BCD, 16'h0043);
    step();

    // Lap while paused.
    stop = 1'b1;
    want("p_st", S_ST, 16'(PAUSED));
    step();
    stop = 1'b0;
    lap  = 1'b1;
    want("plap_out", S_LAP, 16'h0043);
    want("plap_lv",  S_LV,  16'd1);
    step();
    lap = 1'b0;

    // Clear and start together while running: clear wins.
    start = 1'b1;
    step();
    clear = 1'b1;
    want("clr_st",  S_ST,  16'(IDLE));
    want("clr_bcd", S_BCD, 16'h0000);
    want("clr_lap", S_LAP, 16'h0000);
    want("clr_run", S_RUN, 16'd0);
    want("clr_lv",  S_LV,  16'd0);
    step();
    clear = 1'b0;
    start = 1'b0;

    // Lap in IDLE is ignored.
    lap = 1'b1;
    want("idle_lap_lv",  S_LV,  16'd0);
    want("idle_lap_out", S_LAP, 16'h0000);
    step();
    lap = 1'b0;

    // 10000 ticks from zero wraps to 0000 and sets overflow.
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (19997) step();
    want("pre_wrap_bcd", S_BCD, 16'h9999);
    want("pre_wrap_ovf", S_OVF, 16'd0);
    step();
    step();
    want("wrap_bcd", S_BCD, 16'h0000);
    want("wrap_ovf", S_OVF, 16'd1);
    want("wrap_run", S_RUN, 16'd1);
    step();
    clear = 1'b1;
    want("ovf_clr",    S_OVF, 16'd0);
    want("ovf_clr_st", S_ST,  16'(IDLE));
    step();
    clear = 1'b0;

    // Reset mid-operation overrides commands.
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    reset = 1'b1; start = 1'b1; lap = 1'b1;
    want("mrst_bcd", S_BCD, 16'h0000);
    want("mrst_run", S_RUN, 16'd0);
    want("mrst_lap", S_LAP, 16'h0000);
    want("mrst_lv",  S_LV,  16'd0);
    step();
    reset = 1'b0; start = 1'b0; lap = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
